// File: rtl/gcd_rr_scheduler_pkg.sv
// Shared definitions for the round-robin GCD scheduler: FSM state encoding and
// default sizing used by the interface, the scheduler and its GCD engine.
package gcd_rr_scheduler_pkg;

  localparam int GCD_WIDTH = 16;
  localparam int GCD_N_REQ = 4;
  localparam int GCD_ID_W  = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/gcd_rr_scheduler_if.sv
// Request/response bundle between the requesting datapath blocks (master side)
// and the shared GCD scheduler (slave side).
interface gcd_rr_scheduler_if
  import gcd_rr_scheduler_pkg::*;
#(
  parameter int N_REQ = GCD_N_REQ,
  parameter int WIDTH = GCD_WIDTH,
  parameter int ID_W  = GCD_ID_W
);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH-1:0]       rsp_result;
  logic [ID_W-1:0]        rsp_id;
  logic                   busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_id, busy
  );

endinterface

// File: rtl/gcd_rr_scheduler_core.sv
// Iterative subtract-based GCD engine. The scheduler drives load/step; the
// engine reports when the operand pair has converged and what the result is.
module gcd_rr_scheduler_core
  import gcd_rr_scheduler_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;

  // A zero operand or equal operands both terminate; gcd(0,0) falls out as 0.
  assign done   = (a_reg == '0) || (b_reg == '0) || (a_reg == b_reg);
  assign result = (a_reg == '0) ? b_reg : a_reg;

  always_comb begin
    a_next = a_reg;
    b_next = b_reg;
    if (load) begin
      a_next = a_in;
      b_next = b_in;
    end else if (step && !done) begin
      if (a_reg > b_reg) a_next = a_reg - b_reg;
      else               b_next = b_reg - a_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      a_reg <= a_next;
      b_reg <= b_next;
    end
  end

endmodule

// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end that shares one GCD engine among N_REQ requesters and
// returns each result tagged with the owning requester's index.
module gcd_rr_scheduler
  import gcd_rr_scheduler_pkg::*;
#(
  parameter int N_REQ = GCD_N_REQ,
  parameter int WIDTH = GCD_WIDTH,
  parameter int ID_W  = GCD_ID_W
) (
  input  logic               clk,
  input  logic               rst_n,
  gcd_rr_scheduler_if.slave  bus
);

  localparam int SW = ID_W + 1;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   ptr_reg, ptr_next;
  logic [ID_W-1:0]   id_reg, id_next;
  logic [WIDTH-1:0]  result_reg, result_next;

  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  grant_ready;
  logic [ID_W-1:0]   grant_idx;
  logic [WIDTH-1:0]  a_arr [N_REQ];
  logic [WIDTH-1:0]  b_arr [N_REQ];
  logic              load, step;
  logic              core_done;
  logic [WIDTH-1:0]  core_result;

  // Rotate so the slot after the pointer sits at bit 0, isolate the lowest
  // set bit, then rotate back into requester order.
  function automatic logic [N_REQ-1:0] rr_grant(input logic [N_REQ-1:0] valid,
                                                input logic [ID_W-1:0]  ptr);
    logic [SW-1:0]        shamt;
    logic [2*N_REQ-1:0]   dbl;
    logic [N_REQ-1:0]     rot;
    logic [N_REQ-1:0]     pick;
    logic [2*N_REQ-1:0]   back;
    shamt = {1'b0, ptr} + SW'(1);
    dbl   = {valid, valid} >> shamt;
    rot   = dbl[N_REQ-1:0];
    pick  = rot & (~rot + N_REQ'(1));
    back  = {pick, pick} << shamt;
    return back[2*N_REQ-1:N_REQ];
  endfunction

  assign grant = rr_grant(bus.req_valid, ptr_reg);

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_idx = ID_W'(i);
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_operand
      assign a_arr[gi] = bus.req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = bus.req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  gcd_rr_scheduler_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .a_in   (a_arr[grant_idx]),
    .b_in   (b_arr[grant_idx]),
    .done   (core_done),
    .result (core_result)
  );

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    id_next     = id_reg;
    result_next = result_reg;
    grant_ready = '0;
    load        = 1'b0;
    step        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (|grant) begin
          grant_ready = grant;
          load        = 1'b1;
          ptr_next    = grant_idx;
          id_next     = grant_idx;
          state_next  = S_RUN;
        end
      end
      S_RUN: begin
        if (core_done) begin
          result_next = core_result;
          state_next  = S_RESP;
        end else begin
          step = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Pointer resets to the last slot so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      ptr_reg    <= ID_W'(N_REQ - 1);
      id_reg     <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      id_reg     <= id_next;
      result_reg <= result_next;
    end
  end

  assign bus.req_ready  = grant_ready;
  assign bus.rsp_valid  = (state_reg == S_RESP);
  assign bus.rsp_result = result_reg;
  assign bus.rsp_id     = id_reg;
  assign bus.busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Directed and randomised checks of the round-robin GCD scheduler: latency,
// edge operands, arbitration order, back-pressure, reset abort and fairness.
module tb_gcd_rr_scheduler;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gcd_rr_scheduler_if #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) bus ();

  gcd_rr_scheduler #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int           m_ptr;
  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];
  int           waited [N];
  int           issued [N];
  int           served [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gcd_ref(input int a, input int b);
    int x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_valid[i]    = 1'b1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    m_ptr = N - 1;
  endtask

  // Waits (bounded) for a grant, checks it, and steps over the accept edge.
  task automatic accept(input int id, input bit drop);
    int cnt;
    cnt = 0;
    #1;
    while (bus.req_ready == '0 && cnt < 20) begin
      @(posedge clk); #3;
      cnt++;
    end
    check($sformatf("grant_req%0d", id), 32'(bus.req_ready), 32'(1) << id);
    @(posedge clk); #3;
    check("ready_after_accept", 32'(bus.req_ready), 0);
    if (drop) bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int exp_r, input int exp_id, input int exp_lat);
    int lat;
    lat = 0;
    while (!bus.rsp_valid && lat < 200) begin
      @(posedge clk); #3;
      lat++;
    end
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 1);
    check({tag, "_result"}, 32'(bus.rsp_result), exp_r);
    check({tag, "_id"}, 32'(bus.rsp_id), exp_id);
    if (exp_lat >= 0) check({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #3;
    bus.rsp_ready = 1'b0;
    check("rsp_valid_after_handshake", 32'(bus.rsp_valid), 0);
  endtask

  task automatic do_job(input string tag, input int id, input int a, input int b,
                        input int exp_r, input int exp_lat);
    set_req(id, W'(a), W'(b));
    accept(id, 1'b1);
    wait_rsp(tag, exp_r, id, exp_lat);
    finish_rsp();
  endtask

  task automatic raise(input int i);
    opa[i] = W'($urandom_range(0, 31));
    opb[i] = W'($urandom_range(0, 31));
    set_req(i, opa[i], opb[i]);
    waited[i] = 0;
    issued[i]++;
  endtask

  task automatic rnd_job(input bit refill);
    int g, exp_r, cnt;
    bit done;
    if (bus.req_valid == '0) raise($urandom_range(0, N - 1));
    g = rr_pick(bus.req_valid, m_ptr);
    #1;
    cnt = 0;
    while (bus.req_ready == '0 && cnt < 10) begin
      @(posedge clk); #3;
      cnt++;
    end
    check("rnd_grant", 32'(bus.req_ready), 32'(1) << g);
    check("rnd_wait_bound", 32'(waited[g] <= N - 1), 1);
    for (int i = 0; i < N; i++) begin
      if (i != g && bus.req_valid[i]) waited[i]++;
    end
    waited[g] = 0;
    m_ptr = g;
    exp_r = gcd_ref(int'(opa[g]), int'(opb[g]));
    @(posedge clk); #3;
    bus.req_valid[g] = 1'b0;
    if (refill) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) raise(i);
      end
    end
    done = 1'b0;
    cnt  = 0;
    while (!done && cnt < 300) begin
      bus.rsp_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (bus.rsp_valid && bus.rsp_ready) begin
        check("rnd_result", 32'(bus.rsp_result), exp_r);
        check("rnd_id", 32'(bus.rsp_id), g);
        if (int'(bus.rsp_id) == g) served[g]++;
        done = 1'b1;
      end
      @(posedge clk); #3;
      cnt++;
    end
    check("rnd_rsp_timeout", 32'(done), 1);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy_low, guard;

    for (int i = 0; i < N; i++) begin
      waited[i] = 0;
      issued[i] = 0;
      served[i] = 0;
    end
    do_reset();

    // Reset state
    #1;
    check("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    check("reset_rsp_result", 32'(bus.rsp_result), 0);
    check("reset_rsp_id", 32'(bus.rsp_id), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_req_ready", 32'(bus.req_ready), 0);

    // (12,8): two subtractions, response 3 cycles after accept
    do_job("t1_12_8", 0, 12, 8, 4, 3);

    // Terminal operand pairs resolve on the first RUN cycle
    do_job("t2_0_9", 0, 0, 9, 9, 1);
    do_job("t2_9_0", 1, 9, 0, 9, 1);
    do_job("t2_0_0", 2, 0, 0, 0, 1);
    do_job("t2_7_7", 3, 7, 7, 7, 1);

    // Back-pressure in RESP while another requester waits
    set_req(0, 16'd12, 16'd8);
    accept(0, 1'b1);
    set_req(2, 16'd9, 16'd6);
    wait_rsp("t4_hold", 4, 0, 3);
    for (int c = 0; c < 5; c++) begin
      check("t4_result_stable", 32'(bus.rsp_result), 4);
      check("t4_id_stable", 32'(bus.rsp_id), 0);
      check("t4_no_ready_in_resp", 32'(bus.req_ready), 0);
      check("t4_valid_held", 32'(bus.rsp_valid), 1);
      @(posedge clk); #3;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #3;
    bus.rsp_ready = 1'b0;
    check("t4_valid_dropped", 32'(bus.rsp_valid), 0);
    #1;
    check("t4_req2_ready_first_idle", 32'(bus.req_ready), 32'b0100);
    @(posedge clk); #3;
    check("t4_req2_accepted", 32'(bus.busy), 1);
    bus.req_valid[2] = 1'b0;
    wait_rsp("t4_req2", 3, 2, 3);
    finish_rsp();

    // Round-robin order from reset with all requesters active
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 16'd6, 16'd4);
    for (int i = 0; i < N; i++) begin
      accept(i, 1'b1);
      wait_rsp($sformatf("t3_all_%0d", i), 2, i, 3);
      finish_rsp();
    end
    set_req(1, 16'd6, 16'd4);
    set_req(3, 16'd6, 16'd4);
    accept(1, 1'b0);
    wait_rsp("t3_pair_a", 2, 1, 3);
    finish_rsp();
    accept(3, 1'b1);
    wait_rsp("t3_pair_b", 2, 3, 3);
    finish_rsp();
    accept(1, 1'b1);
    wait_rsp("t3_pair_c", 2, 1, 3);
    finish_rsp();

    // Worst-case latency, busy held for the whole job
    set_req(0, 16'd65535, 16'd1);
    accept(0, 1'b1);
    lat = 0;
    busy_low = 0;
    while (!bus.rsp_valid && lat < 70000) begin
      if (!bus.busy) busy_low++;
      @(posedge clk); #3;
      lat++;
    end
    check("t5_latency", lat, 65535);
    check("t5_result", 32'(bus.rsp_result), 1);
    check("t5_busy_low_cycles", busy_low, 0);
    finish_rsp();

    // Reset mid-RUN discards the job and restores requester-0 priority
    set_req(0, 16'd65535, 16'd1);
    accept(0, 1'b1);
    repeat (100) @(posedge clk);
    #3;
    check("t5_busy_mid_run", 32'(bus.busy), 1);
    rst_n = 1'b0;
    bus.req_valid = '0;
    #1;
    check("t5_rst_busy", 32'(bus.busy), 0);
    check("t5_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("t5_rst_rsp_result", 32'(bus.rsp_result), 0);
    check("t5_rst_rsp_id", 32'(bus.rsp_id), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("t5_no_stale_rsp", 32'(bus.rsp_valid), 0);
    check("t5_idle_after_rst", 32'(bus.busy), 0);
    set_req(0, 16'd3, 16'd6);
    set_req(2, 16'd5, 16'd10);
    #1;
    check("t5_req0_first", 32'(bus.req_ready), 32'b0001);
    accept(0, 1'b1);
    wait_rsp("t5_post_rst_0", 3, 0, 2);
    finish_rsp();
    accept(2, 1'b1);
    wait_rsp("t5_post_rst_2", 5, 2, 2);
    finish_rsp();

    // Randomised traffic with reference GCD and fairness bound
    do_reset();
    for (int j = 0; j < 600; j++) rnd_job(1'b1);
    guard = 0;
    while (bus.req_valid != '0 && guard < 20) begin
      rnd_job(1'b0);
      guard++;
    end
    for (int i = 0; i < N; i++) check($sformatf("t6_served_%0d", i), served[i], issued[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
